syn_sram_ctrl: RTL and testbench

SYN_SRAM_CTRL -- requirements
Module: syn_sram_ctrl

---
 rtl/syn_sram_pkg.sv | 28 ++
 rtl/syn_sram_arb.sv | 72 +++++++
 rtl/syn_sram_ctrl.sv | 126 ++++++++++++
 tb/tb_syn_sram_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/syn_sram_pkg.sv
// syn_sram_pkg
//   Shared definitions for the synchronous SRAM controller slice:
//   default parameter constants, the controller FSM state encoding and the
//   access-request record captured at grant time.
//   No ports (package).
package syn_sram_pkg;

  localparam int NUM_CH_DEF  = 2;
  localparam int ADDR_W_DEF  = 18;
  localparam int DATA_W_DEF  = 16;
  localparam int BE_W_DEF    = DATA_W_DEF / 8;
  localparam int ACC_CYC_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  // One client access as latched when the arbiter grants it.
  typedef struct packed {
    logic                  wr;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic [BE_W_DEF-1:0]   be;
  } access_req_t;

endpackage

// File: rtl/syn_sram_arb.sv
// syn_sram_arb
//   Channel arbiter for syn_sram_ctrl. Produces a one-hot grant from the
//   request vector.
//   Policy selected by macro SYN_SRAM_CTRL_RR_ARB_EN:
//     defined   : round-robin, pointer moves to granted+1 after each grant
//     undefined : fixed priority, lowest channel index wins (combinational only)
//   Ports:
//     clk, rst_n  clock / async active-low reset (round-robin build only)
//     advance     a grant is being taken this cycle (round-robin build only)
//     req         per-channel request vector
//     grant       one-hot grant, zero when no request
module syn_sram_arb #(
  parameter int NUM_CH = 2
) (
`ifdef SYN_SRAM_CTRL_RR_ARB_EN
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
`endif
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] grant
);

`ifdef SYN_SRAM_CTRL_RR_ARB_EN
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] next_ptr;
  logic             found;
  int               idx;

  // Search starts at the pointer and wraps, so the channel after the last
  // winner has first chance at the next grant.
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = (idx == NUM_CH - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= next_ptr;
    end
  end
`else
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/syn_sram_ctrl.sv
// syn_sram_ctrl
//   Multi-channel controller for an asynchronous-style SRAM. Each access runs
//   IDLE -> ACCESS (ACC_CYC cycles) -> RECOVER -> IDLE.
//   Arbitration policy set by macro SYN_SRAM_CTRL_RR_ARB_EN (see syn_sram_arb).
//   Ports:
//     clk_ir, rst_il         clock, async active-low reset
//     req_i/wr_i             per-channel request and direction (1=write)
//     addr_i/wdata_i/be_i    per-channel address, write data, byte enables
//     ack_o                  one-cycle grant pulse
//     rd_valid_o, rdata_o    read-complete pulse and shared read data
//     busy_o                 FSM not idle
//     sram_*                 SRAM address, strobes (active-low) and data bus
module syn_sram_ctrl
  import syn_sram_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_CYC = ACC_CYC_DEF,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic                     clk_ir,
  input  logic                     rst_il,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH-1:0]        wr_i,
  input  logic [NUM_CH*ADDR_W-1:0] addr_i,
  input  logic [NUM_CH*DATA_W-1:0] wdata_i,
  input  logic [NUM_CH*BE_W-1:0]   be_i,
  output logic [NUM_CH-1:0]        ack_o,
  output logic [NUM_CH-1:0]        rd_valid_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     busy_o,
  output logic [ADDR_W-1:0]        sram_addr_o,
  output logic [BE_W-1:0]          sram_be_n_o,
  output logic                     sram_ce_n_o,
  output logic                     sram_oe_n_o,
  output logic                     sram_we_n_o,
  inout  wire  [DATA_W-1:0]        sram_dq_io
);

  state_t            state;
  access_req_t       cur;
  access_req_t       sel;
  logic [NUM_CH-1:0] cur_grant;
  logic [NUM_CH-1:0] grant;
  logic [1:0]        acc_cnt;
  logic              take;
  logic              last_acc;
  logic              in_access;

  assign take      = (state == ST_IDLE) && (|req_i);
  assign last_acc  = (acc_cnt == 2'(ACC_CYC - 1));
  assign in_access = (state == ST_ACCESS);

  syn_sram_arb #(
    .NUM_CH(NUM_CH)
  ) u_arb (
`ifdef SYN_SRAM_CTRL_RR_ARB_EN
    .clk    (clk_ir),
    .rst_n  (rst_il),
    .advance(take),
`endif
    .req    (req_i),
    .grant  (grant)
  );

  // Pick the granted channel's fields; grant is one-hot so a plain priority
  // loop behaves as a mux.
  always_comb begin
    sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) begin
        sel.wr    = wr_i[c];
        sel.addr  = ADDR_W_DEF'(addr_i[c*ADDR_W +: ADDR_W]);
        sel.wdata = DATA_W_DEF'(wdata_i[c*DATA_W +: DATA_W]);
        sel.be    = BE_W_DEF'(be_i[c*BE_W +: BE_W]);
      end
    end
  end

  // Access sequencer. The request is frozen at grant so clients may change
  // their inputs as soon as ack_o has pulsed. Read data is taken on the last
  // ACCESS cycle while OE_N is still low.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state     <= ST_IDLE;
      cur       <= '0;
      cur_grant <= '0;
      acc_cnt   <= '0;
      rdata_o   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            state     <= ST_ACCESS;
            cur       <= sel;
            cur_grant <= grant;
            acc_cnt   <= '0;
          end
        end
        ST_ACCESS: begin
          if (last_acc) begin
            state <= ST_RECOVER;
            if (!cur.wr) rdata_o <= sram_dq_io;
          end else begin
            acc_cnt <= acc_cnt + 2'd1;
          end
        end
        ST_RECOVER: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so a reset releases them at once.
  assign ack_o       = take ? grant : '0;
  assign rd_valid_o  = ((state == ST_RECOVER) && !cur.wr) ? cur_grant : '0;
  assign busy_o      = (state != ST_IDLE);
  assign sram_addr_o = ADDR_W'(cur.addr);
  assign sram_ce_n_o = !in_access;
  assign sram_oe_n_o = !(in_access && !cur.wr);
  assign sram_we_n_o = !(in_access && cur.wr);
  assign sram_be_n_o = in_access ? ~BE_W'(cur.be) : '1;
  assign sram_dq_io  = (in_access && cur.wr) ? DATA_W'(cur.wdata) : 'z;

endmodule

// File: tb/tb_syn_sram_ctrl.sv
// tb_syn_sram_ctrl
//   Bench for syn_sram_ctrl: main instance (2 channels, ACC_CYC=1) against a
//   behavioural SRAM, plus a single-channel ACC_CYC=3 instance for strobe
//   width checks. Honours SYN_SRAM_CTRL_RR_ARB_EN for the arbitration check.
module tb_syn_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  req, wr;
  logic [35:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  wire  [1:0]  ack, rd_valid;
  wire  [15:0] rdata;
  wire         busy;
  wire  [17:0] sram_addr;
  wire  [1:0]  sram_be_n;
  wire         ce_n, oe_n, we_n;
  wire  [15:0] dq;

  logic        req3, wr3;
  logic [17:0] addr3;
  logic [15:0] wdata3;
  logic [1:0]  be3;
  wire         ack3, rd_valid3, busy3, ce_n3, oe_n3, we_n3;
  wire  [15:0] rdata3;
  wire  [17:0] sram_addr3;
  wire  [1:0]  be_n3;
  wire  [15:0] dq3;

  syn_sram_ctrl #(.NUM_CH(2), .ADDR_W(18), .DATA_W(16), .ACC_CYC(1)) u_dut (
    .clk_ir(clk), .rst_il(rst_n), .req_i(req), .wr_i(wr), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .ack_o(ack), .rd_valid_o(rd_valid),
    .rdata_o(rdata), .busy_o(busy), .sram_addr_o(sram_addr),
    .sram_be_n_o(sram_be_n), .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n),
    .sram_we_n_o(we_n), .sram_dq_io(dq)
  );

  syn_sram_ctrl #(.NUM_CH(1), .ADDR_W(18), .DATA_W(16), .ACC_CYC(3)) u_dut3 (
    .clk_ir(clk), .rst_il(rst_n), .req_i(req3), .wr_i(wr3), .addr_i(addr3),
    .wdata_i(wdata3), .be_i(be3), .ack_o(ack3), .rd_valid_o(rd_valid3),
    .rdata_o(rdata3), .busy_o(busy3), .sram_addr_o(sram_addr3),
    .sram_be_n_o(be_n3), .sram_ce_n_o(ce_n3), .sram_oe_n_o(oe_n3),
    .sram_we_n_o(we_n3), .sram_dq_io(dq3)
  );

  // Behavioural SRAM: drives the bus on an enabled read, stores enabled
  // bytes at each clock edge while a write strobe is active.
  logic [15:0] mem [0:255];
  assign dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!sram_be_n[0]) mem[sram_addr[7:0]][7:0]  <= dq[7:0];
      if (!sram_be_n[1]) mem[sram_addr[7:0]][15:8] <= dq[15:8];
    end
  end

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int          ch;
    logic [15:0] data;
    int          ackCyc;
  } exp_t;
  exp_t sbQ[$];

  typedef struct {
    int          ch;
    logic        w;
    logic [17:0] a;
    logic [15:0] d;
    logic [1:0]  b;
    logic [15:0] expd;
  } vec_t;
  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Raise a request, wait (bounded) for its ack, queue the expected read
  // result, and drop the request on the following negedge (DUT in ACCESS).
  task automatic applyStimulus(input int ch, input logic w, input logic [17:0] a,
                               input logic [15:0] d, input logic [1:0] b,
                               input logic [15:0] expd, input bit track);
    bit got;
    got = 0;
    wr[ch] = w;
    addr[ch*18 +: 18] = a;
    wdata[ch*16 +: 16] = d;
    be[ch*2 +: 2] = b;
    req[ch] = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      #1;
      if (ack[ch]) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      checkOutput("ack_timeout", 0, 1);
      req[ch] = 1'b0;
      return;
    end
    if (!w && track) sbQ.push_back('{ch, expd, cycle});
    @(negedge clk);
    req[ch] = 1'b0;
  endtask

  // Read-completion monitor and strobe exclusivity.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("we_oe_exclusive", {31'b0, !(!we_n && !oe_n)}, 1);
      if (rd_valid !== 2'b00) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_rd_valid", {30'b0, rd_valid}, 0);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput("rd_valid_ch", {30'b0, rd_valid}, 32'(1 << e.ch));
          checkOutput("rdata", {16'b0, rdata}, {16'b0, e.data});
          checkOutput("rd_latency", cycle - e.ackCyc, 2);
        end
      end
    end
  end

  initial begin
    logic [1:0] seen [4];
    logic [1:0] expAck [4];
    int nAck, weLow, dqDrv, dqBad, busyCnt;
    bit got;

    for (int i = 0; i < 256; i++) mem[i] = 16'(16'h1000 + i);
    vecs[0] = '{0, 1'b1, 18'h00010, 16'hA5C3, 2'b11, 16'h0000};
    vecs[1] = '{0, 1'b0, 18'h00010, 16'h0000, 2'b11, 16'hA5C3};
    vecs[2] = '{1, 1'b1, 18'h00020, 16'h1234, 2'b11, 16'h0000};
    vecs[3] = '{1, 1'b1, 18'h00021, 16'hBEEF, 2'b10, 16'h0000};
    vecs[4] = '{1, 1'b0, 18'h00020, 16'h0000, 2'b11, 16'h1234};
    vecs[5] = '{0, 1'b0, 18'h00021, 16'h0000, 2'b11, 16'hBE21};
    vecs[6] = '{0, 1'b0, 18'h00055, 16'h0000, 2'b11, 16'h1055};
    vecs[7] = '{1, 1'b1, 18'h00030, 16'h7777, 2'b11, 16'h0000};

    rst_n = 1'b0;
    req = '0; wr = '0; addr = '0; wdata = '0; be = '0;
    req3 = 0; wr3 = 0; addr3 = '0; wdata3 = '0; be3 = '0;

    #3;
    checkOutput("rst_ack", {30'b0, ack}, 0);
    checkOutput("rst_rd_valid", {30'b0, rd_valid}, 0);
    checkOutput("rst_rdata", {16'b0, rdata}, 0);
    checkOutput("rst_busy", {31'b0, busy}, 0);
    checkOutput("rst_strobes", {27'b0, ce_n, oe_n, we_n, sram_be_n}, 32'h1F);
    checkOutput("rst_addr", {14'b0, sram_addr}, 0);
    checkOutput("rst_dq_hiz", {31'b0, dq === 16'hzzzz}, 1);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      applyStimulus(vecs[i].ch, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].b,
                    vecs[i].expd, 1);

    // Partial byte-enable write over existing data.
    applyStimulus(0, 1'b1, 18'h00040, 16'h1234, 2'b11, 16'h0, 1);
    applyStimulus(0, 1'b1, 18'h00040, 16'hFFFF, 2'b01, 16'h0, 1);
    #1;
    checkOutput("be01_be_n", {30'b0, sram_be_n}, 32'h2);
    checkOutput("be01_we_oe_ce", {29'b0, we_n, oe_n, ce_n}, 32'h2);
    checkOutput("be01_dq", {16'b0, dq}, 32'hFFFF);
    checkOutput("be01_addr", {14'b0, sram_addr}, 32'h40);
    applyStimulus(0, 1'b0, 18'h00040, 16'h0, 2'b11, 16'h12FF, 1);

    // All-zero byte enables still run a full cycle but store nothing.
    applyStimulus(1, 1'b1, 18'h00050, 16'h5555, 2'b11, 16'h0, 1);
    applyStimulus(1, 1'b1, 18'h00050, 16'h0000, 2'b00, 16'h0, 1);
    #1;
    checkOutput("be00_be_n", {30'b0, sram_be_n}, 32'h3);
    checkOutput("be00_ce_we", {30'b0, ce_n, we_n}, 0);
    checkOutput("be00_busy", {31'b0, busy}, 1);
    checkOutput("rdata_hold", {16'b0, rdata}, 32'h12FF);
    applyStimulus(1, 1'b0, 18'h00050, 16'h0, 2'b11, 16'h5555, 1);

    // Reset during a read ACCESS.
    applyStimulus(0, 1'b0, 18'h00010, 16'h0, 2'b11, 16'h0, 0);
    #1;
    checkOutput("pre_rst_oe_n", {31'b0, oe_n}, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_strobes", {27'b0, ce_n, oe_n, we_n, sram_be_n}, 32'h1F);
    checkOutput("midrst_dq_hiz", {31'b0, dq === 16'hzzzz}, 1);
    checkOutput("midrst_busy", {31'b0, busy}, 0);
    checkOutput("midrst_rdata", {16'b0, rdata}, 0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("midrst_rd_valid", {30'b0, rd_valid}, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Two channels requesting continuously, from a fresh arbiter pointer.
`ifdef SYN_SRAM_CTRL_RR_ARB_EN
    expAck = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    expAck = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    wr = 2'b11;
    addr = {18'h00061, 18'h00060};
    wdata = {16'h0B0B, 16'h0A0A};
    be = 4'hF;
    req = 2'b11;
    nAck = 0;
    for (int k = 0; k < 40 && nAck < 4; k++) begin
      #1;
      if (ack != 2'b00) begin
        seen[nAck] = ack;
        nAck++;
      end
      @(negedge clk);
    end
    req = 2'b00;
    checkOutput("arb_ack_count", nAck, 4);
    for (int i = 0; i < 4; i++)
      if (i < nAck) checkOutput($sformatf("arb_ack%0d", i), {30'b0, seen[i]},
                                {30'b0, expAck[i]});
    repeat (4) @(negedge clk);

    // ACC_CYC=3 write strobe widths.
    wr3 = 1'b1; addr3 = 18'h5; wdata3 = 16'hC0DE; be3 = 2'b11; req3 = 1'b1;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      #1;
      if (ack3) got = 1;
      else @(negedge clk);
    end
    checkOutput("acc3_ack", {31'b0, got}, 1);
    @(negedge clk);
    req3 = 1'b0;
    weLow = 0; dqDrv = 0; dqBad = 0; busyCnt = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (!we_n3) weLow++;
      if (dq3 === 16'hC0DE) dqDrv++;
      if (dq3 !== 16'hzzzz && we_n3) dqBad++;
      if (busy3) busyCnt++;
      @(negedge clk);
    end
    checkOutput("acc3_we_low", weLow, 3);
    checkOutput("acc3_dq_driven", dqDrv, 3);
    checkOutput("acc3_dq_outside", dqBad, 0);
    checkOutput("acc3_busy", busyCnt, 4);

    for (int k = 0; k < 10 && sbQ.size() != 0; k++) @(negedge clk);
    checkOutput("scoreboard_drained", sbQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
